// File: rtl/onehot_encoder_buf.sv
// onehot_encoder_buf: registered W-to-log2(W) encoder with a 2-entry output queue.
// This is the inverse of the registered 3-to-8 decoder. The decoder maps code 0 to an
// all-zero word and code k (k>=1) to 1<<k. This block encodes each accepted word, marks
// words the decoder can never produce, and keeps a saturating count of those words.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset; has priority over every other input
//   in_valid   in_data is valid
//   in_ready   a word can be accepted this cycle (decoded from the state register only)
//   in_data    word to encode
//   out_valid  head of the output queue is valid
//   out_ready  consumer takes the head this cycle
//   out_code   encoded index of the head entry
//   out_err    head entry came from an illegal word
//   err_count  saturating count of illegal words accepted
//   clr_err    synchronous clear of err_count; wins over a same-cycle increment
module onehot_encoder_buf #(
   parameter int unsigned W   = 8,
   parameter int unsigned CW  = 8,
   parameter int unsigned CWD = $clog2(W)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [CWD-1:0] out_code,
   output logic           out_err,
   output logic [CW-1:0]  err_count,
   input  logic           clr_err
);

   typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

   state_e           state;
   logic [CWD-1:0]   head_code, tail_code;
   logic             head_err, tail_err;

   logic             accept, pop;
   logic [CWD-1:0]   enc_code;
   logic             enc_err;
   logic             seen, multi;

   // Both handshake outputs decode from the state register, so out_ready has no
   // combinational path to in_ready.
   assign in_ready  = (state != StFull);
   assign out_valid = (state != StEmpty);
   assign out_code  = head_code;
   assign out_err   = head_err;

   assign accept = in_valid & in_ready;
   assign pop    = out_valid & out_ready;

   // The code is the index of the highest set bit.
   // A word is illegal if it has more than one bit set or if it is the lone bit-0 word.
   always_comb begin
      enc_code = '0;
      seen     = 1'b0;
      multi    = 1'b0;
      for (int i = 0; i < int'(W); i++) begin
         if (in_data[i]) begin
            if (seen) multi = 1'b1;
            seen     = 1'b1;
            enc_code = CWD'(i);
         end
      end
      enc_err = multi | (in_data == W'(1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StEmpty;
         head_code <= '0;
         head_err  <= 1'b0;
         tail_code <= '0;
         tail_err  <= 1'b0;
         err_count <= '0;
      end else begin
         unique case (state)
            StEmpty: begin
               if (accept) begin
                  head_code <= enc_code;
                  head_err  <= enc_err;
                  state     <= StOne;
               end
            end
            StOne: begin
               if (accept && pop) begin
                  // On a simultaneous accept and pop, the new word replaces the head.
                  head_code <= enc_code;
                  head_err  <= enc_err;
               end else if (accept) begin
                  tail_code <= enc_code;
                  tail_err  <= enc_err;
                  state     <= StFull;
               end else if (pop) begin
                  state <= StEmpty;
               end
            end
            StFull: begin
               if (pop) begin
                  head_code <= tail_code;
                  head_err  <= tail_err;
                  state     <= StOne;
               end
            end
            default: state <= StEmpty;
         endcase

         // Illegal words are counted when they are accepted, not when they are popped.
         if (clr_err) begin
            err_count <= '0;
         end else if (accept && enc_err && (err_count != {CW{1'b1}})) begin
            err_count <= err_count + 1'b1;
         end
      end
   end

endmodule
